vector_memory_sequencer: RTL and testbench

Memory-stage controller that shares the single 16-bit data-memory port between scalar loads/stores and 128-bit vector loads/stores. It decodes the control and data fields produced by the Execute/Memory pipeline register and sequences each vector access as eight 16-bit beats. While a vector access is in progress it stalls the front of the pipeline, so the Execute/Memory register holds its contents. For vector loads it assembles the 128-bit result that goes to the Memory/Writeback register.

---
 rtl/vector_memory_sequencer.sv | 142 ++++++++++++++
 tb/tb_vector_memory_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_memory_sequencer.sv
// Memory-stage controller sharing one 16-bit RAM port between scalar accesses
// and 128-bit vector loads/stores that are sequenced as eight 16-bit beats.
module vector_memory_sequencer #(
    parameter int BEATS  = 8,
    parameter int WORD_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vector_wre_memory,
    input  logic                      write_memory_enable_memory,
    input  logic                      select_writeback_data_mux_memory,
    input  logic [WORD_W-1:0]         ALUresult_memory,
    input  logic [WORD_W-1:0]         srcB_memory,
    input  logic [7:0]                vector_address_data_memory,
    input  logic [BEATS*WORD_W-1:0]   vector_data_memory,
    input  logic [WORD_W-1:0]         mem_read_data,
    output logic [WORD_W-1:0]         mem_address,
    output logic [WORD_W-1:0]         mem_write_data,
    output logic                      mem_wre,
    output logic [WORD_W-1:0]         scalar_read_data,
    output logic [BEATS*WORD_W-1:0]   vector_load_data,
    output logic                      stall_pipeline,
    output logic                      busy
);

    localparam int VEC_W = BEATS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        VSTORE,
        VLOAD,
        VLOAD_DRAIN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      counter;
    logic [2:0]      next_counter;
    logic [2:0]      prev_beat;
    logic [7:0]      base_reg;
    logic [VEC_W-1:0] data_reg;
    logic [VEC_W-1:0] load_reg;
    logic            vec_store;
    logic            vec_load;
    logic            scalar_store;

    assign vec_store    = vector_wre_memory & write_memory_enable_memory;
    assign vec_load     = vector_wre_memory & ~write_memory_enable_memory
                          & select_writeback_data_mux_memory;
    assign scalar_store = ~vector_wre_memory & write_memory_enable_memory;
    assign prev_beat    = counter - 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= 3'd0;
            base_reg <= 8'd0;
            data_reg <= '0;
            load_reg <= '0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            if (state == IDLE && (vec_store || vec_load))
                base_reg <= vector_address_data_memory;
            if (state == IDLE && vec_store)
                data_reg <= vector_data_memory;
            // Read data lags the issued address by one cycle, so it lands in the previous beat's slice.
            if (state == VLOAD)
                load_reg[{prev_beat, 4'b0000} +: WORD_W] <= mem_read_data;
            if (state == VLOAD_DRAIN)
                load_reg[VEC_W-1 -: WORD_W] <= mem_read_data;
        end
    end

    always_comb begin
        next_state       = state;
        next_counter     = counter;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_wre          = 1'b0;
        stall_pipeline   = 1'b0;
        vector_load_data = load_reg;

        case (state)
            IDLE: begin
                if (vec_store) begin
                    mem_address    = {5'b0, vector_address_data_memory, 3'd0};
                    mem_write_data = vector_data_memory[WORD_W-1:0];
                    mem_wre        = 1'b1;
                    stall_pipeline = 1'b1;
                    next_counter   = 3'd1;
                    next_state     = VSTORE;
                end else if (vec_load) begin
                    mem_address    = {5'b0, vector_address_data_memory, 3'd0};
                    stall_pipeline = 1'b1;
                    next_counter   = 3'd1;
                    next_state     = VLOAD;
                end else begin
                    mem_address    = ALUresult_memory;
                    mem_write_data = srcB_memory;
                    mem_wre        = scalar_store;
                end
            end
            VSTORE: begin
                mem_address    = {5'b0, base_reg, counter};
                mem_write_data = data_reg[{counter, 4'b0000} +: WORD_W];
                mem_wre        = 1'b1;
                stall_pipeline = (counter != 3'd7);
                next_counter   = counter + 3'd1;
                if (counter == 3'd7)
                    next_state = IDLE;
            end
            VLOAD: begin
                mem_address    = {5'b0, base_reg, counter};
                stall_pipeline = 1'b1;
                next_counter   = counter + 3'd1;
                if (counter == 3'd7)
                    next_state = VLOAD_DRAIN;
            end
            VLOAD_DRAIN: begin
                // Forward the last beat so the Memory/Writeback register sees the whole vector now.
                vector_load_data = {mem_read_data, load_reg[VEC_W-WORD_W-1:0]};
                next_state       = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (reset) begin
            mem_address      = '0;
            mem_write_data   = '0;
            mem_wre          = 1'b0;
            stall_pipeline   = 1'b0;
            vector_load_data = '0;
        end
    end

    assign busy             = ~reset & (state != IDLE);
    assign scalar_read_data = reset ? '0 : mem_read_data;

endmodule

// File: tb/tb_vector_memory_sequencer.sv
// Self-checking bench for vector_memory_sequencer: a behavioural synchronous RAM
// plus scoreboards of expected RAM writes and expected assembled vector loads.
module tb_vector_memory_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         vector_wre_memory;
    logic         write_memory_enable_memory;
    logic         select_writeback_data_mux_memory;
    logic [15:0]  ALUresult_memory;
    logic [15:0]  srcB_memory;
    logic [7:0]   vector_address_data_memory;
    logic [127:0] vector_data_memory;
    logic [15:0]  mem_read_data;
    logic [15:0]  mem_address;
    logic [15:0]  mem_write_data;
    logic         mem_wre;
    logic [15:0]  scalar_read_data;
    logic [127:0] vector_load_data;
    logic         stall_pipeline;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_writes[$];
    logic [127:0] exp_loads[$];

    logic [15:0]  ram [0:2047];
    logic         preload;
    logic [15:0]  cap_addr;
    logic [15:0]  cap_data;
    logic         cap_wre;

    always #5 clk = ~clk;

    vector_memory_sequencer dut (
        .clk                              (clk),
        .reset                            (reset),
        .vector_wre_memory                (vector_wre_memory),
        .write_memory_enable_memory       (write_memory_enable_memory),
        .select_writeback_data_mux_memory (select_writeback_data_mux_memory),
        .ALUresult_memory                 (ALUresult_memory),
        .srcB_memory                      (srcB_memory),
        .vector_address_data_memory       (vector_address_data_memory),
        .vector_data_memory               (vector_data_memory),
        .mem_read_data                    (mem_read_data),
        .mem_address                      (mem_address),
        .mem_write_data                   (mem_write_data),
        .mem_wre                          (mem_wre),
        .scalar_read_data                 (scalar_read_data),
        .vector_load_data                 (vector_load_data),
        .stall_pipeline                   (stall_pipeline),
        .busy                             (busy)
    );

    // RAM port values are captured mid-cycle so the RAM model never races the DUT's clock edge.
    always @(negedge clk) begin
        cap_addr = mem_address;
        cap_data = mem_write_data;
        cap_wre  = mem_wre;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++)
                ram[i] <= 16'(i) ^ 16'h5A5A;
        end else if (cap_wre) begin
            ram[cap_addr[10:0]] <= cap_data;
        end
        mem_read_data <= ram[cap_addr[10:0]];
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic vw, input logic we,
                                 input logic sel, input logic [15:0] alu,
                                 input logic [15:0] srcb, input logic [7:0] vaddr,
                                 input logic [127:0] vdata);
        @(posedge clk);
        #1;
        reset                            = rst;
        vector_wre_memory                = vw;
        write_memory_enable_memory       = we;
        select_writeback_data_mux_memory = sel;
        ALUresult_memory                 = alu;
        srcB_memory                      = srcb;
        vector_address_data_memory       = vaddr;
        vector_data_memory               = vdata;
        @(negedge clk);
    endtask

    task automatic nop();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 128'h0);
    endtask

    task automatic pushWrites(input logic [7:0] base, input logic [127:0] vec,
                              input int count);
        for (int i = 0; i < count; i++)
            exp_writes.push_back({5'b0, base, 3'(i), vec[i*16 +: 16]});
    endtask

    // Scoreboard consumer: every RAM write and every drain cycle must match the head of its queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_wre) begin
                if (exp_writes.size() == 0)
                    checkOutput("unexpected_write", mem_wre, 1'b0);
                else
                    checkOutput("write", {mem_address, mem_write_data}, exp_writes.pop_front());
            end
            if (busy && !stall_pipeline && !mem_wre) begin
                checkOutput("drain_addr", mem_address, 16'h0);
                if (exp_loads.size() == 0)
                    checkOutput("unexpected_drain", busy, 1'b0);
                else
                    checkOutput("vector_load", vector_load_data, exp_loads.pop_front());
            end
        end
    end

    logic [127:0] vec_a;
    logic [127:0] vec_b;
    logic [127:0] vec_c;
    int stall_cnt;
    int busy_cnt;

    initial begin
        for (int i = 0; i < 8; i++) begin
            vec_a[i*16 +: 16] = 16'h1111 * 16'(i + 1);
            vec_b[i*16 +: 16] = 16'hA000 + 16'(i);
            vec_c[i*16 +: 16] = 16'hC000 + 16'(i);
        end
        preload = 1'b1;
        reset   = 1'b1;
        vector_wre_memory = 1'b0;
        write_memory_enable_memory = 1'b0;
        select_writeback_data_mux_memory = 1'b0;
        ALUresult_memory = '0;
        srcB_memory = '0;
        vector_address_data_memory = '0;
        vector_data_memory = '0;

        // Reset with an active scalar store on the inputs: every output must stay 0.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 16'hFFFF, 8'h0, 128'h0);
        preload = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 16'hFFFF, 8'h0, 128'h0);
        checkOutput("rst_mem_wre", mem_wre, 1'b0);
        checkOutput("rst_mem_address", mem_address, 16'h0);
        checkOutput("rst_mem_write_data", mem_write_data, 16'h0);
        checkOutput("rst_stall", stall_pipeline, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_vector_load_data", vector_load_data, 128'h0);
        checkOutput("rst_scalar_read_data", scalar_read_data, 16'h0);

        $display("[TB] scalar store then scalar load");
        exp_writes.push_back({16'h0042, 16'hBEEF});
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, 16'hBEEF, 8'h0, 128'h0);
        checkOutput("sst_stall", stall_pipeline, 1'b0);
        checkOutput("sst_mem_wre", mem_wre, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0, 8'h0, 128'h0);
        checkOutput("sld_address", mem_address, 16'h0042);
        checkOutput("sld_mem_wre", mem_wre, 1'b0);
        checkOutput("sld_stall", stall_pipeline, 1'b0);
        nop();
        checkOutput("sld_data", scalar_read_data, 16'hBEEF);

        $display("[TB] vector store base 0x03");
        pushWrites(8'h03, vec_a, 8);
        stall_cnt = 0;
        busy_cnt  = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0)
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 8'h03, vec_a);
            else if (c < 8)
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 8'hFF, ~vec_a ^ 128'(c));
            else
                nop();
            stall_cnt += int'(stall_pipeline);
            busy_cnt  += int'(busy);
        end
        checkOutput("vst_stall_cycles", stall_cnt, 7);
        checkOutput("vst_busy_cycles", busy_cnt, 7);
        checkOutput("vst_writes_left", exp_writes.size(), 0);

        $display("[TB] vector load base 0x03 then scalar load 0x0005");
        exp_loads.push_back(vec_a);
        stall_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 8)
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 8'h03, 128'h0);
            else if (c < 10)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0, 8'h0, 128'h0);
            else
                nop();
            stall_cnt += int'(stall_pipeline);
            if (c == 8) begin
                checkOutput("drain_busy", busy, 1'b1);
                checkOutput("drain_mem_wre", mem_wre, 1'b0);
                checkOutput("drain_vector", vector_load_data, vec_a);
            end
            if (c == 9)
                checkOutput("post_drain_address", mem_address, 16'h0005);
            if (c == 10) begin
                checkOutput("post_drain_scalar", scalar_read_data, 16'h0005 ^ 16'h5A5A);
                checkOutput("vector_held", vector_load_data, vec_a);
            end
        end
        checkOutput("vld_stall_cycles", stall_cnt, 8);
        checkOutput("vld_loads_left", exp_loads.size(), 0);

        $display("[TB] vector no-op");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 8'h05, vec_b);
            checkOutput("noop_stall", stall_pipeline, 1'b0);
            checkOutput("noop_mem_wre", mem_wre, 1'b0);
            checkOutput("noop_busy", busy, 1'b0);
        end

        $display("[TB] reset during vector store after beat 3");
        pushWrites(8'h10, vec_b, 4);
        for (int c = 0; c < 4; c++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 8'h10, vec_b);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 8'h10, vec_b);
        checkOutput("abort_mem_wre", mem_wre, 1'b0);
        checkOutput("abort_address", mem_address, 16'h0);
        checkOutput("abort_stall", stall_pipeline, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 128'h0);
        nop();
        checkOutput("abort_idle", busy, 1'b0);
        checkOutput("abort_writes_left", exp_writes.size(), 0);
        checkOutput("abort_beat4_untouched", ram[11'h084], 16'h0084 ^ 16'h5A5A);
        checkOutput("abort_beat3_written", ram[11'h083], 16'hA003);

        pushWrites(8'h10, vec_c, 8);
        for (int c = 0; c < 10; c++) begin
            if (c < 8)
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 8'h10, vec_c);
            else
                nop();
        end
        checkOutput("restart_writes_left", exp_writes.size(), 0);
        checkOutput("restart_beat4", ram[11'h084], 16'hC004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
